// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and helpers for the fetch stall controller
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {RUN, SC_DRAIN, SC_WAIT, SC_REL} sc_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $zero is hard-wired, so a write to it can never create a dependency
  function automatic logic reg_match(input logic [4:0] dest, input logic [4:0] src,
                                     input logic uses);
    return uses && (dest != REG_ZERO) && (dest == src);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use and branch-operand hazard compare
module hazard_detect
  import fetch_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_dest,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_dest,
  output logic       ld_haz,
  output logic       br_haz
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = reg_match(ex_dest, id_rs, id_uses_rs) || reg_match(ex_dest, id_rt, id_uses_rt);
  assign mem_hit = reg_match(mem_dest, id_rs, id_uses_rs) || reg_match(mem_dest, id_rt, id_uses_rt);

  assign ld_haz = ex_mem_read && ex_hit;
  // Branches compare in ID, so they also wait on ALU results in EX and loads in MEM
  assign br_haz = id_is_branch && !ld_haz &&
                  ((ex_reg_write && ex_hit) || (mem_mem_read && mem_hit));

endmodule

// File: rtl/fetch_stall_ctrl.sv
// rtl/fetch_stall_ctrl.sv - PC/IF-ID stall, flush and syscall sequencing controller
// Optional stall statistics counters: FETCH_STALL_STATS_EN
module fetch_stall_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
`ifdef FETCH_STALL_STATS_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_usesRs_i,
  input  logic       id_usesRt_i,
  input  logic       id_isBranch_i,
  input  logic       id_isSyscall_i,
  input  logic       taken_i,
  input  logic       jump_i,
  input  logic       ex_memRead_i,
  input  logic       ex_regWrite_i,
  input  logic [4:0] ex_dest_i,
  input  logic       mem_memRead_i,
  input  logic [4:0] mem_dest_i,
  input  logic       syscallDone_i,
`ifdef FETCH_STALL_STATS_EN
  input  logic             statsClr_i,
  output logic [CNT_W-1:0] ldStallCnt_o,
  output logic [CNT_W-1:0] brStallCnt_o,
  output logic [CNT_W-1:0] scStallCnt_o,
`endif
  output logic       loadStall_o,
  output logic       branchStall_o,
  output logic       syscallFlag_o,
  output logic       idexBubble_o,
  output logic       ifidFlush_o,
  output logic       busy_o
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  sc_state_t     state;
  logic [DW-1:0] drain_cnt;
  logic          done_lat;
  logic          ld_haz;
  logic          br_haz;
  logic          run;
  logic          holding;

  hazard_detect u_hazard (
    .id_rs        (id_rs_i),
    .id_rt        (id_rt_i),
    .id_uses_rs   (id_usesRs_i),
    .id_uses_rt   (id_usesRt_i),
    .id_is_branch (id_isBranch_i),
    .ex_mem_read  (ex_memRead_i),
    .ex_reg_write (ex_regWrite_i),
    .ex_dest      (ex_dest_i),
    .mem_mem_read (mem_memRead_i),
    .mem_dest     (mem_dest_i),
    .ld_haz       (ld_haz),
    .br_haz       (br_haz)
  );

  assign run     = (state == RUN);
  assign holding = (state == SC_DRAIN) || (state == SC_WAIT);

  always_comb begin
    loadStall_o   = run && ld_haz;
    branchStall_o = run && br_haz;
    ifidFlush_o   = run && !ld_haz && !br_haz && (taken_i || jump_i);
    syscallFlag_o = holding;
    idexBubble_o  = run ? (ld_haz || br_haz) : holding;
    busy_o        = !run;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      drain_cnt <= '0;
      done_lat  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // The syscall itself must advance into EX, so entry waits for any hazard to clear
          if (id_isSyscall_i && !ld_haz && !br_haz) begin
            state     <= SC_DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end
        end
        SC_DRAIN: begin
          if (syscallDone_i) done_lat <= 1'b1;
          if (drain_cnt == '0) state <= SC_WAIT;
          else drain_cnt <= drain_cnt - DW'(1);
        end
        SC_WAIT: begin
          if (syscallDone_i || done_lat) begin
            state    <= SC_REL;
            done_lat <= 1'b0;
          end
        end
        SC_REL:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef FETCH_STALL_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ldStallCnt_o <= '0;
      brStallCnt_o <= '0;
      scStallCnt_o <= '0;
    end else if (statsClr_i) begin
      ldStallCnt_o <= '0;
      brStallCnt_o <= '0;
      scStallCnt_o <= '0;
    end else begin
      if (loadStall_o && (ldStallCnt_o != '1)) ldStallCnt_o <= ldStallCnt_o + CNT_W'(1);
      if (branchStall_o && (brStallCnt_o != '1)) brStallCnt_o <= brStallCnt_o + CNT_W'(1);
      if (syscallFlag_o && (scStallCnt_o != '1)) scStallCnt_o <= scStallCnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb/tb_fetch_stall_ctrl.sv - scoreboard bench for fetch_stall_ctrl (optional FETCH_STALL_STATS_EN)
module tb_fetch_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs, id_rt, ex_dest, mem_dest;
  logic       uses_rs, uses_rt, is_branch, is_syscall, taken, jump;
  logic       ex_mem_read, ex_reg_write, mem_mem_read, sc_done;
  logic       load_stall, branch_stall, syscall_flag, idex_bubble, ifid_flush, busy;
`ifdef FETCH_STALL_STATS_EN
  logic        stats_clr;
  logic [31:0] ld_cnt, br_cnt, sc_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [5:0] v;
  } sb_t;
  sb_t sb_q[$];

  logic [5:0] outs;
  assign outs = {load_stall, branch_stall, syscall_flag, idex_bubble, ifid_flush, busy};

  always #5 clk = ~clk;

  fetch_stall_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_usesRs_i    (uses_rs),
    .id_usesRt_i    (uses_rt),
    .id_isBranch_i  (is_branch),
    .id_isSyscall_i (is_syscall),
    .taken_i        (taken),
    .jump_i         (jump),
    .ex_memRead_i   (ex_mem_read),
    .ex_regWrite_i  (ex_reg_write),
    .ex_dest_i      (ex_dest),
    .mem_memRead_i  (mem_mem_read),
    .mem_dest_i     (mem_dest),
    .syscallDone_i  (sc_done),
`ifdef FETCH_STALL_STATS_EN
    .statsClr_i     (stats_clr),
    .ldStallCnt_o   (ld_cnt),
    .brStallCnt_o   (br_cnt),
    .scStallCnt_o   (sc_cnt),
`endif
    .loadStall_o    (load_stall),
    .branchStall_o  (branch_stall),
    .syscallFlag_o  (syscall_flag),
    .idexBubble_o   (idex_bubble),
    .ifidFlush_o    (ifid_flush),
    .busy_o         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_dest = 5'd0; mem_dest = 5'd0;
    uses_rs = 1'b0; uses_rt = 1'b0; is_branch = 1'b0; is_syscall = 1'b0;
    taken = 1'b0; jump = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    mem_mem_read = 1'b0; sc_done = 1'b0;
`ifdef FETCH_STALL_STATS_EN
    stats_clr = 1'b0;
`endif
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  // exp bits: {loadStall, branchStall, syscallFlag, idexBubble, ifidFlush, busy}
  task automatic expect_o(input string tag, input logic [5:0] v);
    sb_t e;
    e.tag = tag;
    e.v   = v;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      sb_t e;
      e = sb_q.pop_front();
      check_eq(e.tag, {26'd0, outs}, {26'd0, e.v});
    end
  end

  task automatic syscall_entry(input string tag);
    next(); is_syscall = 1'b1; expect_o({tag, "_enter"}, 6'b000000);
  endtask

  initial begin
    idle();
    #3;
    check_eq("reset_outs", {26'd0, outs}, 32'd0);
`ifdef FETCH_STALL_STATS_EN
    check_eq("reset_ldcnt", ld_cnt, 32'd0);
`endif
    #5 reset = 1'b1;

    // load-use on rs
    next(); ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5'd8; id_rs = 5'd8; uses_rs = 1;
    expect_o("lu_stall", 6'b100100);
    next(); mem_mem_read = 1; mem_dest = 5'd8; id_rs = 5'd8; uses_rs = 1;
    expect_o("lu_release", 6'b000000);

    // ALU producer feeding a branch, stalled taken ignored, then taken flushes
    next(); ex_reg_write = 1; ex_dest = 5'd9; is_branch = 1; id_rs = 5'd9; uses_rs = 1; taken = 1;
    expect_o("br_alu_stall", 6'b010100);
    next(); is_branch = 1; id_rs = 5'd9; uses_rs = 1; mem_dest = 5'd9; taken = 1;
    expect_o("br_taken_flush", 6'b000010);

    // load producer feeding a branch: load stall then branch stall
    next(); ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5'd10; is_branch = 1; id_rt = 5'd10; uses_rt = 1;
    expect_o("br_ld_c0", 6'b100100);
    next(); mem_mem_read = 1; mem_dest = 5'd10; is_branch = 1; id_rt = 5'd10; uses_rt = 1;
    expect_o("br_ld_c1", 6'b010100);
    next(); is_branch = 1; id_rt = 5'd10; uses_rt = 1;
    expect_o("br_ld_c2", 6'b000000);

    // $zero and unused sources never stall; jump flushes
    next(); ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5'd0; id_rs = 5'd0; uses_rs = 1; is_branch = 1;
    expect_o("zero_reg", 6'b000000);
    next(); ex_mem_read = 1; ex_dest = 5'd8; id_rt = 5'd8; uses_rt = 0;
    expect_o("unused_src", 6'b000000);
    next(); jump = 1;
    expect_o("jump_flush", 6'b000010);

    // syscall blocked by load-use, then done in RUN ignored
    next(); is_syscall = 1; ex_mem_read = 1; ex_dest = 5'd4; id_rs = 5'd4; uses_rs = 1;
    expect_o("sc_blocked", 6'b100100);
    next(); sc_done = 1;
    expect_o("done_in_run", 6'b000000);

    // syscall, done at wait cycle 2
    syscall_entry("sc1");
    next(); expect_o("sc1_drain0", 6'b001101);
    next(); ex_mem_read = 1; ex_dest = 5'd3; id_rs = 5'd3; uses_rs = 1; taken = 1;
    expect_o("sc1_drain1_masked", 6'b001101);
    next(); expect_o("sc1_drain2", 6'b001101);
    next(); expect_o("sc1_wait0", 6'b001101);
    next(); sc_done = 1; expect_o("sc1_wait1", 6'b001101);
    next(); expect_o("sc1_rel", 6'b000001);
    next(); expect_o("sc1_run", 6'b000000);

    // syscall, done latched during drain cycle 1 -> single wait cycle
    syscall_entry("sc2");
    next(); sc_done = 1; expect_o("sc2_drain0", 6'b001101);
    next(); expect_o("sc2_drain1", 6'b001101);
    next(); expect_o("sc2_drain2", 6'b001101);
    next(); expect_o("sc2_wait0", 6'b001101);
    next(); expect_o("sc2_rel", 6'b000001);
    next(); expect_o("sc2_run", 6'b000000);

    // async reset while waiting
    syscall_entry("sc3");
    next(); expect_o("sc3_drain0", 6'b001101);
    next(); sc_done = 1; expect_o("sc3_drain1", 6'b001101);
    next(); expect_o("sc3_drain2", 6'b001101);
    next(); expect_o("sc3_wait0", 6'b001101);
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check_eq("async_rst_outs", {26'd0, outs}, 32'd0);
`ifdef FETCH_STALL_STATS_EN
    check_eq("async_rst_sccnt", sc_cnt, 32'd0);
`endif
    #1 reset = 1'b1;
    // a set latch would have let SC_WAIT exit at once; after reset it must be clear
    next(); expect_o("post_rst_run", 6'b000000);
    syscall_entry("sc4");
    next(); expect_o("sc4_drain0", 6'b001101);
    next(); expect_o("sc4_drain1", 6'b001101);
    next(); expect_o("sc4_drain2", 6'b001101);
    next(); expect_o("sc4_wait0", 6'b001101);
    next(); expect_o("sc4_wait1_latch_clr", 6'b001101);
    next(); sc_done = 1; expect_o("sc4_wait2", 6'b001101);
    next(); expect_o("sc4_rel", 6'b000001);

`ifdef FETCH_STALL_STATS_EN
    next(); stats_clr = 1; ex_mem_read = 1; ex_dest = 5'd8; id_rs = 5'd8; uses_rs = 1;
    expect_o("clr_lu", 6'b100100);
    next(); ex_mem_read = 1; ex_dest = 5'd8; id_rs = 5'd8; uses_rs = 1;
    expect_o("cnt_lu", 6'b100100);
    next();
    @(negedge clk);
    #1;
    check_eq("ldcnt_after_lu", ld_cnt, 32'd1);
    check_eq("brcnt_after_lu", br_cnt, 32'd0);
    check_eq("sccnt_after_clr", sc_cnt, 32'd0);
`endif

    next(); expect_o("tail", 6'b000000);
    @(posedge clk);
    #1;
    check_eq("sb_drain", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
